// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array command sequencer: sizes, op-codes and FSM states.
package mac_pkg;

  localparam int N_MAC     = 8;
  localparam int DW        = 8;
  localparam int SUM_W     = 19;
  localparam int OUT_BYTES = 3;
  localparam int LANE_W    = $clog2(N_MAC);

  localparam logic [1:0] OP_WR_W = 2'b00;
  localparam logic [1:0] OP_WR_A = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_CLR_W,
    ST_CLR_A
  } state_t;

  function automatic logic [N_MAC-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
    logic [N_MAC-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mac_sum_serializer.sv
// Captures the adder-tree sum (or running accumulator when MAC_CTRL_ACC_EN is defined)
// and presents it LSB-first as bytes selected by the read-phase index.
module mac_sum_serializer
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
`ifdef MAC_CTRL_ACC_EN
  input  logic             acc_clr,
  input  logic             clr_all,
`endif
  input  logic [SUM_W-1:0] sum_in,
  input  logic             rd_active,
  input  logic [1:0]       rd_idx,
  output logic [7:0]       out_byte,
  output logic             out_valid
);

  localparam int RD_W = OUT_BYTES * 8;

  logic [RD_W-1:0] rd_val;

`ifdef MAC_CTRL_ACC_EN
  logic [RD_W-1:0] acc;

  // Wraps modulo 2^RD_W; acc_clr restarts the running total from this sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr_all) begin
      acc <= '0;
    end else if (capture) begin
      acc <= (acc_clr ? '0 : acc) + RD_W'(sum_in);
    end
  end

  assign rd_val = acc;
`else
  logic [SUM_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (capture) begin
      sum_q <= sum_in;
    end
  end

  assign rd_val = RD_W'(sum_q);
`endif

  always_comb begin
    out_byte = '0;
    if (rd_active) begin
      case (rd_idx)
        2'd0:    out_byte = rd_val[7:0];
        2'd1:    out_byte = rd_val[15:8];
        default: out_byte = rd_val[23:16];
      endcase
    end
  end

  assign out_valid = rd_active;

endmodule

// File: rtl/mac_array_ctrl.sv
// Command sequencer for the MAC array: lane writes, two-phase clear, 3-byte sum readout.
// Optional accumulator enabled by defining MAC_CTRL_ACC_EN.
module mac_array_ctrl
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_addr,
  input  logic [DW-1:0]    cmd_data,
  output logic [N_MAC-1:0] mac_wr_w,
  output logic [N_MAC-1:0] mac_wr_a,
  output logic [DW-1:0]    mac_wdata,
  input  logic [SUM_W-1:0] sum_in,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             err_addr
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and nothing is buffered while it is low.

  state_t     state;
  logic       addr_bad;
  logic       rd_active;
  logic [1:0] rd_idx;

  assign cmd_ready = (state == ST_IDLE);
  assign addr_bad  = ({1'b0, cmd_addr} >= 7'(N_MAC));
  assign rd_active = (state == ST_RD0) || (state == ST_RD1) || (state == ST_RD2);
  assign rd_idx    = (state == ST_RD0) ? 2'd0 : (state == ST_RD1) ? 2'd1 : 2'd2;

`ifdef MAC_CTRL_ACC_EN
  logic acc_clr_q;
  logic clr_go;
  assign clr_go = cmd_ready && cmd_valid && (cmd_op == OP_CLR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mac_wr_w  <= '0;
      mac_wr_a  <= '0;
      mac_wdata <= '0;
      err_addr  <= 1'b0;
`ifdef MAC_CTRL_ACC_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      mac_wr_w <= '0;
      mac_wr_a <= '0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WR_W, OP_WR_A: begin
                if (addr_bad) begin
                  err_addr <= 1'b1;
                end else begin
                  if (cmd_op == OP_WR_W) mac_wr_w <= lane_onehot(cmd_addr[LANE_W-1:0]);
                  else                   mac_wr_a <= lane_onehot(cmd_addr[LANE_W-1:0]);
                  mac_wdata <= cmd_data;
                end
              end
              OP_RD: begin
                state <= ST_WAIT;
`ifdef MAC_CTRL_ACC_EN
                acc_clr_q <= cmd_addr[0];
`endif
              end
              default: begin
                // Weights first: the MAC lets a weight write win over an activation write.
                state     <= ST_CLR_W;
                mac_wr_w  <= '1;
                mac_wdata <= '0;
              end
            endcase
          end
        end
        ST_WAIT:  state <= ST_RD0;
        ST_RD0:   state <= ST_RD1;
        ST_RD1:   state <= ST_RD2;
        ST_RD2:   state <= ST_IDLE;
        ST_CLR_W: begin
          state     <= ST_CLR_A;
          mac_wr_a  <= '1;
          mac_wdata <= '0;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  mac_sum_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (state == ST_WAIT),
`ifdef MAC_CTRL_ACC_EN
    .acc_clr   (acc_clr_q),
    .clr_all   (clr_go),
`endif
    .sum_in    (sum_in),
    .rd_active (rd_active),
    .rd_idx    (rd_idx),
    .out_byte  (out_byte),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: MAC-array stand-in, arithmetic reference model,
// byte scoreboard, directed cases plus random command stream.
module tb_mac_array_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_addr = 6'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [7:0] mac_wr_w, mac_wr_a, mac_wdata;
  logic [18:0] sum_in;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       err_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  // MAC array stand-in
  logic [7:0] lane_w [0:N-1];
  logic [7:0] lane_a [0:N-1];
  int env_sum;

  // reference model state
  int unsigned m_w [0:N-1];
  int unsigned m_a [0:N-1];
  logic        m_err = 1'b0;
  int unsigned m_acc = 0;

  mac_array_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .mac_wr_w  (mac_wr_w),
    .mac_wr_a  (mac_wr_a),
    .mac_wdata (mac_wdata),
    .sum_in    (sum_in),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .err_addr  (err_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N; i++) begin
      lane_w[i] = 8'd0;
      lane_a[i] = 8'd0;
      m_w[i] = 0;
      m_a[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mac_wr_w[i])      lane_w[i] <= mac_wdata;
      else if (mac_wr_a[i]) lane_a[i] <= mac_wdata;
    end
  end

  always_comb begin
    env_sum = 0;
    for (int i = 0; i < N; i++) env_sum += int'(lane_w[i]) * int'(lane_a[i]);
    sum_in = env_sum[18:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, out_byte}, 32'hFFFF_FFFF);
        else                   check("out_byte", {24'd0, out_byte}, {24'd0, exp_q.pop_front()});
      end else begin
        check("idle_byte_zero", {24'd0, out_byte}, 32'd0);
      end
      check("wr_exclusive", {31'd0, (mac_wr_w != 0) && (mac_wr_a != 0)}, 32'd0);
    end
  end

  task automatic model_read(input logic [5:0] addr);
    int unsigned s;
    logic [23:0] v;
    s = 0;
    for (int i = 0; i < N; i++) s += m_w[i] * m_a[i];
`ifdef MAC_CTRL_ACC_EN
    m_acc = ((addr[0] ? 0 : m_acc) + s) & 32'h00FF_FFFF;
    v = m_acc[23:0];
`else
    v = s[23:0];
`endif
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[23:16]);
  endtask

  // wait until the controller is back in IDLE; returns busy cycles seen
  task automatic wait_idle(output int busy);
    busy = 0;
    @(negedge clk);
    while (!cmd_ready && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, busy >= 20}, 32'd0);
  endtask

  // driver
  task automatic send(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] data);
    int n;
    logic [7:0] exp_pulse;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ready_timeout", {31'd0, n >= 20}, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        exp_pulse = 8'd0;
        if (addr < N) begin
          exp_pulse = 8'd1 << addr;
          if (op == 2'b00) m_w[addr] = data;
          else             m_a[addr] = data;
        end else begin
          m_err = 1'b1;
        end
        check("wr_w_pulse", {24'd0, mac_wr_w}, {24'd0, (op == 2'b00) ? exp_pulse : 8'd0});
        check("wr_a_pulse", {24'd0, mac_wr_a}, {24'd0, (op == 2'b01) ? exp_pulse : 8'd0});
        if (addr < N) check("wr_data", {24'd0, mac_wdata}, {24'd0, data});
        check("err_addr", {31'd0, err_addr}, {31'd0, m_err});
      end
      2'b10: model_read(addr);
      default: begin
        for (int i = 0; i < N; i++) begin
          m_w[i] = 0;
          m_a[i] = 0;
        end
        m_acc = 0;
        check("clr_w_all", {24'd0, mac_wr_w}, 32'hFF);
        check("clr_w_noa", {24'd0, mac_wr_a}, 32'h0);
        check("clr_w_data", {24'd0, mac_wdata}, 32'h0);
        @(posedge clk);
        #1;
        check("clr_a_all", {24'd0, mac_wr_a}, 32'hFF);
        check("clr_a_now", {24'd0, mac_wr_w}, 32'h0);
        check("clr_a_data", {24'd0, mac_wdata}, 32'h0);
        check("err_after_clr", {31'd0, err_addr}, {31'd0, m_err});
      end
    endcase
  endtask

  task automatic load_all_ff();
    for (int i = 0; i < N; i++) send(2'b00, 6'(i), 8'hFF);
    for (int i = 0; i < N; i++) send(2'b01, 6'(i), 8'hFF);
  endtask

  initial begin
    int busy;
    // reset state
    #12;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_w", {24'd0, mac_wr_w}, 32'd0);
    check("rst_wr_a", {24'd0, mac_wr_a}, 32'd0);
    check("rst_wdata", {24'd0, mac_wdata}, 32'd0);
    check("rst_out", {23'd0, out_valid, out_byte}, 32'd0);
    check("rst_err", {31'd0, err_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // case 1: full load then read
    load_all_ff();
    send(2'b10, 6'd0, 8'd0);
    wait_idle(busy);
    check("case1_drained", exp_q.size(), 32'd0);

    // case 4: clear then read zero
    send(2'b11, 6'd0, 8'd0);
    send(2'b10, 6'd0, 8'd0);
    wait_idle(busy);

    // case 2: write directly followed by read
    send(2'b01, 6'd3, 8'd7);
    send(2'b00, 6'd3, 8'd5);
    send(2'b10, 6'd0, 8'd0);
    wait_idle(busy);
    check("read_busy_cycles", busy, 32'd4);
    check("case2_drained", exp_q.size(), 32'd0);

    // case 3: bad lane
    send(2'b00, 6'd9, 8'h55);
    send(2'b11, 6'd0, 8'd0);
    send(2'b01, 6'd2, 8'h11);
    send(2'b10, 6'd0, 8'd0);
    wait_idle(busy);

    // case 5: reset during RD1
    load_all_ff();
    send(2'b10, 6'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_byte", {24'd0, out_byte}, 32'd0);
    check("mid_rst_wr", {16'd0, mac_wr_w, mac_wr_a}, 32'd0);
    check("mid_rst_err", {31'd0, err_addr}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    m_err = 1'b0;
    m_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b10, 6'd0, 8'd0);
    wait_idle(busy);
    check("post_rst_drained", exp_q.size(), 32'd0);

`ifdef MAC_CTRL_ACC_EN
    // case 6: accumulate across reads, then restart
    send(2'b11, 6'd0, 8'd0);
    load_all_ff();
    send(2'b10, 6'd0, 8'd0);
    send(2'b10, 6'd0, 8'd0);
    send(2'b10, 6'd1, 8'd0);
    wait_idle(busy);
`endif

    // random command stream
    for (int t = 0; t < 80; t++) begin
      send(2'($urandom_range(0, 3)), 6'($urandom_range(0, 9)), 8'($urandom));
    end
    wait_idle(busy);
    check("final_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
Command sequencer for the 8-lane 8-bit MAC array and its adder tree. It accepts byte-wide commands and turns them into one-hot weight and activation write pulses. It also clears the array with a two-phase sequence and captures the 19-bit adder-tree sum, which it streams out as three bytes. It sits between the pin-level decode (ui_in/uio_in) and the MAC instances, and it drives uo_out.

Parameters:
N_MAC, 8, number of MAC lanes (power of 2, max 64)
DW, 8, operand width
SUM_W, 19, adder-tree sum width (2*DW + log2(N_MAC))
OUT_BYTES, 3, bytes per readout (ceil(SUM_W/8))

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept (high only in IDLE)
cmd_op  in  2  00 wr weight, 01 wr activation, 10 read sum, 11 clear all
cmd_addr  in  6  lane index (op 00/01); op 10 bit0 = acc clear (feature only)
cmd_data  in  DW  write data
mac_wr_w  out  N_MAC  one-hot weight write enables
mac_wr_a  out  N_MAC  one-hot activation write enables
mac_wdata  out  DW  data to all lanes
sum_in  in  SUM_W  adder-tree sum (combinational from MAC regs)
out_byte  out  8  readout byte
out_valid  out  1  out_byte valid this cycle
err_addr  out  1  sticky: write to lane >= N_MAC seen

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - State is IDLE.
  - mac_wr_w, mac_wr_a, mac_wdata, out_byte and err_addr are all 0.
  - out_valid is 0. cmd_ready is 1 once rst_n deasserts.
- Accept: on a rising edge with cmd_valid & cmd_ready. Commands are never queued. cmd_valid while cmd_ready is low is ignored.
- FSM states: IDLE, WAIT, RD0, RD1, RD2, CLR_W, CLR_A.
- Write (op 00/01), accepted at edge k:
  - mac_wr_w[addr] or mac_wr_a[addr] is registered high for exactly cycle k..k+1, with mac_wdata = cmd_data.
  - State stays IDLE, so back-to-back writes run one per cycle.
  - addr >= N_MAC: no pulse, err_addr set. It stays set until reset.
- Read (op 10), accepted at edge k:
  - IDLE->WAIT.
  - Edge k+1: sum_in is captured into sum_q and the FSM moves to RD0. A write accepted at edge k-1 has landed by then.
  - RD0/RD1/RD2 present sum_q[7:0], [15:8] and zero-extended [18:16] on successive cycles, with out_valid high.
  - RD2->IDLE.
  - Read latency: first byte valid 1 cycle after acceptance.
- Clear (op 11), accepted at edge k:
  - CLR_W: all mac_wr_w high, mac_wdata = 0, for one cycle.
  - CLR_A: all mac_wr_a high, mac_wdata = 0, for one cycle.
  - Then IDLE.
  - Two phases are required because the MAC gives weight-write priority over activation-write.
- Output rules:
  - mac_wr_w and mac_wr_a are never both nonzero in the same cycle.
  - out_byte is 0 when out_valid is low.
- Reset mid-read or mid-clear: the sequence is aborted, the FSM returns to IDLE and no further pulses or bytes are produced.

Optional Feature:
Macro: MAC_CTRL_ACC_EN.
- Defined:
  - Adds a 24-bit accumulator, acc, reset to 0.
  - At read capture: acc <= (cmd_addr[0] ? 0 : acc) + sum_in, wrapping mod 2^24. cmd_addr[0] is latched at acceptance.
  - The three readout bytes come from the new acc.
  - Clear (op 11) also zeroes acc.
- Undefined: no accumulator. Readout is the zero-extended sum_in, and cmd_addr is ignored for op 10.

Decomposition:
- Shared package mac_pkg holds:
  - op-code constants OP_WR_W, OP_WR_A, OP_RD, OP_CLR;
  - the FSM state enum;
  - N_MAC, DW, SUM_W, OUT_BYTES.
- One sub-module: mac_sum_serializer. It holds sum_q (or acc) and the byte mux, and drives out_byte/out_valid from an RD-phase index.
- The FSM and write-enable decode stay in mac_array_ctrl.

Test Plan:
1. Reset then load all lanes with w=0xFF and a=0xFF (16 back-to-back writes, cmd_ready held at 1), then read -> bytes 0x08, 0xF0, 0x07 (sum 520200) on 3 consecutive out_valid cycles.
2. Write w[3]=5 at edge k, read at edge k+1 -> sum_q = 5*a[3], proving WAIT covers the in-flight write; cmd_ready is low for 4 cycles.
3. Write with cmd_addr=9 (data 0x55) -> no mac_wr pulse, err_addr=1 and still 1 after a later clear; other lanes unchanged.
4. Clear after case 1 -> one cycle of all-ones mac_wr_w, then one cycle of all-ones mac_wr_a, both with data 0; next read -> 0x00, 0x00, 0x00.
5. rst_n low during RD1 -> out_valid drops immediately, all outputs 0, cmd_ready=1 after release; a new read completes normally.
6. With MAC_CTRL_ACC_EN: run case 1 read twice (addr[0]=0) -> second readout 0x10, 0xE0, 0x0F (1040400); read with addr[0]=1 -> 0x08, 0xF0, 0x07.
